// File: rtl/iir_stim_gen.sv
// iir_stim_gen: LFSR/ramp/walking-one stimulus source with per-vector hold and MISR response compaction
module iir_stim_gen #(
    parameter int                     WIDTH     = 32,
    parameter int                     LANES     = 4,
    parameter logic [WIDTH/LANES-1:0] LFSR_POLY = 8'hB8,
    parameter logic [WIDTH/LANES-1:0] SEED      = 8'h01,
    parameter logic [WIDTH-1:0]       MISR_POLY = 32'h8020_0003,
    parameter int                     CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [7:0]       hold_cycles,
    input  logic [CNT_W-1:0] num_vectors,
    output logic [WIDTH-1:0] in_data,
    output logic             vec_strobe,
    input  logic [WIDTH-1:0] dut_out,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] vec_idx,
    output logic             busy,
    output logic             done
);
    localparam int LANE_W = WIDTH / LANES;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [7:0] hold_q, hold_d, cnt_q, cnt_d;
    logic [CNT_W-1:0] num_q, num_d, idx_q, idx_d;
    logic [WIDTH-1:0] data_q, data_d, sig_q, sig_d, next_vec, lfsr_vec, init_vec;
    logic [LANE_W-1:0] lane;
    logic strobe_q, strobe_d, cap, last;
    always_comb begin
        lfsr_vec = '0;
        lane = '0;
        for (int i = 0; i < LANES; i++) begin
            lane = data_q[i*LANE_W +: LANE_W];
            lfsr_vec[i*LANE_W +: LANE_W] = lane == '0 ? LANE_W'(1) : {lane[LANE_W-2:0], ^(lane & LFSR_POLY)};
        end
    end
    assign next_vec = mode_q == 2'd0 ? lfsr_vec :
                      mode_q == 2'd1 ? data_q + 1'b1 :
                      mode_q == 2'd2 ? {data_q[WIDTH-2:0], data_q[WIDTH-1]} : data_q;
    assign init_vec = mode == 2'd1 ? '0 : mode == 2'd2 ? WIDTH'(1) : {LANES{SEED}};
    assign cap  = cnt_q == hold_q - 8'd1;
    assign last = num_q != '0 && idx_q == num_q - 1'b1;
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        hold_d   = hold_q;
        num_d    = num_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        sig_d    = sig_q;
        strobe_d = 1'b0;
        if (state_q == RUN) begin
            if (stop) begin
                state_d = IDLE;
            end else begin
                cnt_d = cap ? '0 : cnt_q + 8'd1;
                if (cap) begin
                    sig_d = {sig_q[WIDTH-2:0], ^(sig_q & MISR_POLY)} ^ dut_out;
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        data_d   = next_vec;
                        idx_d    = idx_q + 1'b1;
                        strobe_d = 1'b1;
                    end
                end
            end
        end else if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d  = RUN;
            mode_d   = mode;
            hold_d   = hold_cycles == 8'd0 ? 8'd1 : hold_cycles;
            num_d    = num_vectors;
            cnt_d    = '0;
            idx_d    = '0;
            sig_d    = '0;
            data_d   = init_vec;
            strobe_d = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            hold_q   <= 8'd1;
            num_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            sig_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            hold_q   <= hold_d;
            num_q    <= num_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            sig_q    <= sig_d;
            strobe_q <= strobe_d;
        end
    end
    assign in_data    = data_q;
    assign signature  = sig_q;
    assign vec_idx    = idx_q;
    assign vec_strobe = strobe_q;
    assign busy       = state_q == RUN;
    assign done       = state_q == DONE;
endmodule

// File: tb/tb_iir_stim_gen.sv
// tb_iir_stim_gen: directed vector checks of iir_stim_gen in 8-bit single-lane and 32-bit four-lane builds
module tb_iir_stim_gen;
    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, stop = 1'b0;
    logic [1:0] mode = '0;
    logic [7:0] hold = '0;
    logic [15:0] num = '0;
    logic [7:0] d8 = '0;
    logic [7:0] a_data, a_sig;
    logic [15:0] a_idx, b_idx, z_idx;
    logic a_strobe, a_busy, a_done;
    logic [31:0] b_data, b_sig, z_data, z_sig;
    logic b_strobe, b_busy, b_done, z_strobe, z_busy, z_done;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    iir_stim_gen #(.WIDTH(8), .LANES(1), .LFSR_POLY(8'hB8), .SEED(8'h01), .MISR_POLY(8'h8E), .CNT_W(16)) u8 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .hold_cycles(hold),
        .num_vectors(num), .in_data(a_data), .vec_strobe(a_strobe), .dut_out(d8),
        .signature(a_sig), .vec_idx(a_idx), .busy(a_busy), .done(a_done));
    iir_stim_gen u32 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .hold_cycles(hold),
        .num_vectors(num), .in_data(b_data), .vec_strobe(b_strobe), .dut_out(32'h0),
        .signature(b_sig), .vec_idx(b_idx), .busy(b_busy), .done(b_done));
    iir_stim_gen #(.SEED(8'h00)) u32z (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .hold_cycles(hold),
        .num_vectors(num), .in_data(z_data), .vec_strobe(z_strobe), .dut_out(32'h0),
        .signature(z_sig), .vec_idx(z_idx), .busy(z_busy), .done(z_done));
    typedef struct {
        logic start; logic stop; logic [1:0] mode; logic [7:0] hold; logic [15:0] num;
        logic [7:0] e_data; logic [15:0] e_idx; logic e_strobe; logic e_busy; logic e_done;
    } vec_t;
    vec_t tv[9];
    logic [7:0] walk[10];
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic wait_done(input int max);
        int n = 0;
        while (!a_done && n < max) begin
            step();
            n++;
        end
        chk("done_within_bound", a_done, 1);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        tv[0] = '{1'b1, 1'b0, 2'd0, 8'd1, 16'd6, 8'h01, 16'd0, 1'b1, 1'b1, 1'b0};
        tv[1] = '{1'b0, 1'b0, 2'd0, 8'd1, 16'd6, 8'h02, 16'd1, 1'b1, 1'b1, 1'b0};
        tv[2] = '{1'b0, 1'b0, 2'd0, 8'd1, 16'd6, 8'h04, 16'd2, 1'b1, 1'b1, 1'b0};
        tv[3] = '{1'b1, 1'b0, 2'd1, 8'd5, 16'd2, 8'h08, 16'd3, 1'b1, 1'b1, 1'b0};
        tv[4] = '{1'b0, 1'b0, 2'd0, 8'd1, 16'd6, 8'h11, 16'd4, 1'b1, 1'b1, 1'b0};
        tv[5] = '{1'b0, 1'b0, 2'd0, 8'd1, 16'd6, 8'h23, 16'd5, 1'b1, 1'b1, 1'b0};
        tv[6] = '{1'b0, 1'b0, 2'd0, 8'd1, 16'd6, 8'h23, 16'd5, 1'b0, 1'b0, 1'b1};
        tv[7] = '{1'b0, 1'b0, 2'd0, 8'd1, 16'd6, 8'h23, 16'd5, 1'b0, 1'b0, 1'b1};
        tv[8] = '{1'b0, 1'b1, 2'd0, 8'd1, 16'd6, 8'h23, 16'd5, 1'b0, 1'b0, 1'b0};
        walk = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
        step();
        chk("rst_data", a_data, 0);
        chk("rst_sig", a_sig, 0);
        chk("rst_idx", a_idx, 0);
        chk("rst_strobe", a_strobe, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            start = tv[i].start; stop = tv[i].stop; mode = tv[i].mode;
            hold = tv[i].hold; num = tv[i].num;
            step();
            chk($sformatf("tv%0d_data", i), a_data, tv[i].e_data);
            chk($sformatf("tv%0d_idx", i), a_idx, tv[i].e_idx);
            chk($sformatf("tv%0d_strobe", i), a_strobe, tv[i].e_strobe);
            chk($sformatf("tv%0d_busy", i), a_busy, tv[i].e_busy);
            chk($sformatf("tv%0d_done", i), a_done, tv[i].e_done);
        end
        start = 1'b0; stop = 1'b0;
        mode = 2'd0; hold = 8'd31; num = 16'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("l32_first", b_data, 32'h0101_0101);
        chk("l32_strobe0", b_strobe, 1);
        chk("lockup_first", z_data, 32'h0);
        for (int i = 0; i < 30; i++) begin
            step();
            chk($sformatf("l32_hold%0d", i), {b_strobe, b_data}, {1'b0, 32'h0101_0101});
        end
        step();
        chk("l32_second", b_data, 32'h0202_0202);
        chk("l32_strobe1", b_strobe, 1);
        chk("l32_idx1", b_idx, 1);
        chk("lockup_recover", z_data, 32'h0101_0101);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("l32_stopped", b_busy, 0);
        mode = 2'd2; hold = 8'd0; num = 16'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step();
            chk($sformatf("walk%0d", k), {a_strobe, a_data}, {1'b1, walk[k]});
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("walk_stop_busy", a_busy, 0);
        chk("walk_stop_done", a_done, 0);
        chk("walk_stop_idx", a_idx, 9);
        chk("walk_stop_data", a_data, 8'h02);
        step();
        chk("walk_idle_idx", a_idx, 9);
        chk("walk_idle_data", a_data, 8'h02);
        mode = 2'd1; hold = 8'd2; num = 16'd3; d8 = 8'hFF; start = 1'b1;
        step();
        start = 1'b0;
        chk("misr_cleared", a_sig, 0);
        chk("ramp_first", a_data, 0);
        wait_done(20);
        chk("misr_sig", a_sig, 8'hFD);
        chk("misr_data", a_data, 8'h02);
        chk("misr_idx", a_idx, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rerun_busy", a_busy, 1);
        wait_done(20);
        chk("misr_rerun_sig", a_sig, 8'hFD);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("capstop_busy", a_busy, 0);
        chk("capstop_sig", a_sig, 0);
        chk("capstop_idx", a_idx, 0);
        mode = 2'd0; hold = 8'd1; num = 16'd0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("mid_busy", a_busy, 1);
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        chk("mid_rst", {a_data, a_sig, a_idx, a_strobe, a_busy, a_done}, 0);
        chk("mid_rst32", {b_data, b_sig, b_idx, b_strobe, b_busy, b_done}, 0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", a_busy, 0);
        chk("startstop_strobe", a_strobe, 0);
        chk("startstop_data", a_data, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
